// File: rtl/bus_pkg.sv
// Shared definitions for the memory-mapped bus controller: FSM state
// encoding, the address bits used for region decode and default region map.
package bus_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        LO   = 3'd2,
        HI   = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    // Address bits compared against the region bases
    localparam int REGION_MSB = 31;
    localparam int REGION_LSB = 20;
    localparam int REGION_W   = REGION_MSB - REGION_LSB + 1;

    // Default four-slave map: slave k lives at region k+1, slave 0 is 16-bit
    localparam logic [47:0] DEF_SLV_BASE    = {12'h004, 12'h003, 12'h002, 12'h001};
    localparam logic [3:0]  DEF_NARROW_MASK = 4'b0001;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational region decoder: compares the top address bits against every
// slave base and returns a one-hot hit vector (lowest index wins on overlap),
// a mapped flag and whether the selected slave is a 16-bit one.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int                 NSLV        = 4,
    parameter logic [NSLV*12-1:0] SLV_BASE    = DEF_SLV_BASE,
    parameter logic [NSLV-1:0]    NARROW_MASK = DEF_NARROW_MASK
) (
    input  logic [REGION_W-1:0] region,
    output logic [NSLV-1:0]     hit,
    output logic                any_hit,
    output logic                is_narrow
);

    logic [NSLV-1:0] match;

    // One comparator per slave region
    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_match
            assign match[gi] = (region == SLV_BASE[12*gi +: 12]);
        end
    endgenerate

    // Isolate the lowest set bit so overlapping regions resolve to the lower slave
    assign hit       = match & (-match);
    assign any_hit   = |match;
    assign is_narrow = |(hit & NARROW_MASK);

endmodule

// File: rtl/bus_ctrl.sv
// Memory-mapped bus controller: decodes a CPU request onto one of NSLV
// slaves with a req/ack handshake, splits 16-bit slaves into lo/hi beats and
// answers unmapped addresses with an error ack.
// Optional feature macro: BUS_TIMEOUT_EN adds an 8-bit wait-state counter that
// aborts a beat with an error ack after TIMEOUT cycles without s_ready.
module bus_ctrl
    import bus_pkg::*;
#(
    parameter int                 NSLV        = 4,
    parameter logic [NSLV*12-1:0] SLV_BASE    = DEF_SLV_BASE,
    parameter logic [NSLV-1:0]    NARROW_MASK = DEF_NARROW_MASK
`ifdef BUS_TIMEOUT_EN
    ,
    parameter int                 TIMEOUT     = 255
`endif
) (
    input  logic               sck,
    input  logic               rst,
    input  logic               en,
    input  logic               rw,
    input  logic [3:0]         sel,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ack,
    output logic               err,
    output logic [NSLV-1:0]    s_cs,
    output logic               s_rw,
    output logic [3:0]         s_sel,
    output logic [19:0]        s_addr,
    output logic [31:0]        s_wdata,
    input  logic [NSLV*32-1:0] s_rdata,
    input  logic [NSLV-1:0]    s_ready
);

    state_t          state_reg, state_next;
    logic [NSLV-1:0] hit_reg;
    logic            narrow_reg;
    logic            rw_reg;
    logic [3:0]      sel_reg;
    logic [19:2]     addr_reg;
    logic [31:0]     wdata_reg;
    logic [31:0]     rdata_reg;

    logic [NSLV-1:0] dec_hit;
    logic            dec_any;
    logic            dec_narrow;
    logic            ready_sel;
    logic            timeout_hit;
    logic            beat;
    logic [31:0]     slot_data [NSLV];
    logic [31:0]     slv_rdata;

    // Byte-offset bits never reach the slaves; words are addressed only
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    bus_addr_decode #(
        .NSLV        (NSLV),
        .SLV_BASE    (SLV_BASE),
        .NARROW_MASK (NARROW_MASK)
    ) u_decode (
        .region    (addr[REGION_MSB:REGION_LSB]),
        .hit       (dec_hit),
        .any_hit   (dec_any),
        .is_narrow (dec_narrow)
    );

    // Read-data mux: only the latched slave's lane survives the OR below
    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_rdata
            assign slot_data[gi] = hit_reg[gi] ? s_rdata[32*gi +: 32] : 32'h0;
        end
    endgenerate

    // OR-reduce the masked lanes into the selected slave's read data
    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            slv_rdata = slv_rdata | slot_data[i];
        end
    end

    assign ready_sel = |(s_ready & hit_reg);

`ifdef BUS_TIMEOUT_EN
    logic [7:0] wait_cnt_reg;

    assign timeout_hit = (wait_cnt_reg == 8'(TIMEOUT - 1));

    // Wait-state counter: restarts on every state change, counts unanswered beat cycles
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if (state_next != state_reg) begin
            wait_cnt_reg <= '0;
        end else if ((state_reg == ACC || state_reg == LO || state_reg == HI) && !ready_sel) begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus handshake outputs decoded from the current state
    always_comb begin
        state_next = state_reg;
        ack        = 1'b0;
        err        = 1'b0;
        s_cs       = '0;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    if (!dec_any)       state_next = ERR;
                    else if (dec_narrow) state_next = LO;
                    else                state_next = ACC;
                end
            end
            ACC: begin
                s_cs = hit_reg;
                if (ready_sel)        state_next = DONE;
                else if (timeout_hit) state_next = ERR;
            end
            LO: begin
                s_cs = hit_reg;
                if (ready_sel)        state_next = HI;
                else if (timeout_hit) state_next = ERR;
            end
            HI: begin
                s_cs = hit_reg;
                if (ready_sel)        state_next = DONE;
                else if (timeout_hit) state_next = ERR;
            end
            DONE: begin
                ack        = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                ack        = 1'b1;
                err        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch and read-data capture; an error path clears rdata on entry to ERR
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            hit_reg    <= '0;
            narrow_reg <= 1'b0;
            rw_reg     <= 1'b0;
            sel_reg    <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        hit_reg    <= dec_hit;
                        narrow_reg <= dec_narrow;
                        rw_reg     <= rw;
                        sel_reg    <= sel;
                        addr_reg   <= addr[19:2];
                        wdata_reg  <= wdata;
                        if (!dec_any) rdata_reg <= '0;
                    end
                end
                ACC: begin
                    if (ready_sel)        rdata_reg <= slv_rdata;
                    else if (timeout_hit) rdata_reg <= '0;
                end
                LO: begin
                    if (ready_sel)        rdata_reg[15:0] <= slv_rdata[15:0];
                    else if (timeout_hit) rdata_reg <= '0;
                end
                HI: begin
                    if (ready_sel)        rdata_reg[31:16] <= slv_rdata[15:0];
                    else if (timeout_hit) rdata_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    // Slave-side drive: narrow slaves see one 16-bit half per beat
    assign beat    = (state_reg == HI);
    assign rdata   = rdata_reg;
    assign s_rw    = rw_reg;
    assign s_sel   = narrow_reg ? {2'b00, (beat ? sel_reg[3:2] : sel_reg[1:0])} : sel_reg;
    assign s_addr  = narrow_reg ? {addr_reg, beat, 1'b0} : {addr_reg, 2'b00};
    assign s_wdata = narrow_reg ? {16'h0, (beat ? wdata_reg[31:16] : wdata_reg[15:0])} : wdata_reg;

endmodule
